// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch front end with one outstanding imem request and a 1-entry hold buffer.
// Optional feature macro PERF_COUNTER_EN adds the perf_fetched/perf_dropped wrapping counters.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        halted
`ifdef PERF_COUNTER_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic        r_halted;
  logic        r_idValid;
  logic [31:0] r_idInstr;
  logic [31:0] r_idPc;
  logic [31:0] r_idPc4;
  logic [31:0] r_bufInstr;
  logic [31:0] r_bufPc;
  logic [31:0] r_bufPc4;

  logic [1:0]  w_stateNext;
  logic [31:0] w_pcNext;
  logic        w_dropNext;
  logic        w_haltedNext;
  logic        w_loadResp;
  logic        w_loadBuf;
  logic        w_fillBuf;
  logic        w_discard;
  logic        w_flush;
  logic        w_handoff;
  logic        w_reqFire;
  logic        w_outFree;
  logic        w_inWait;
  logic        w_inHold;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_redirectPc;

  assign w_inWait     = (r_state == ST_WAIT);
  assign w_inHold     = (r_state == ST_HOLD);
  assign w_flush      = (halt || redirect_valid) && (r_state != ST_HALT);
  assign w_handoff    = r_idValid && id_ready;
  assign w_outFree    = !r_idValid || id_ready;
  assign w_pcPlus4    = r_pc + 32'd4;
  assign w_redirectPc = redirect_pc & 32'hFFFF_FFFC;

  // A same-cycle flush must never launch a request, and nothing is requested during reset or after halt.
  assign imem_req_valid = reset && (r_state == ST_REQ) && !redirect_valid && !halt && !r_halted;
  assign imem_req_addr  = r_pc;
  assign w_reqFire      = imem_req_valid && imem_req_ready;

  assign id_valid = r_idValid;
  assign id_instr = r_idInstr;
  assign id_pc    = r_idPc;
  assign id_pc4   = r_idPc4;
  assign halted   = r_halted;

  always_comb begin
    w_stateNext  = r_state;
    w_pcNext     = r_pc;
    w_dropNext   = r_drop;
    w_haltedNext = r_halted;
    w_loadResp   = 1'b0;
    w_loadBuf    = 1'b0;
    w_fillBuf    = 1'b0;
    w_discard    = 1'b0;
    if (w_flush) begin
      if (halt) begin
        w_haltedNext = 1'b1;
      end else begin
        w_pcNext = w_redirectPc;
      end
      // An outstanding fetch must still be absorbed, so remember to drop it instead of leaving WAIT.
      if (w_inWait && !imem_resp_valid) begin
        w_dropNext  = 1'b1;
        w_stateNext = ST_WAIT;
      end else begin
        w_discard   = w_inWait;
        w_dropNext  = 1'b0;
        w_stateNext = (halt || r_halted) ? ST_HALT : ST_REQ;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_reqFire) begin
            w_stateNext = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (r_drop) begin
              w_discard   = 1'b1;
              w_dropNext  = 1'b0;
              w_stateNext = r_halted ? ST_HALT : ST_REQ;
            end else begin
              w_pcNext = w_pcPlus4;
              if (w_outFree) begin
                w_loadResp  = 1'b1;
                w_stateNext = ST_REQ;
              end else begin
                w_fillBuf   = 1'b1;
                w_stateNext = ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            w_loadBuf   = 1'b1;
            w_stateNext = ST_REQ;
          end
        end
        default: begin
          w_stateNext = ST_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_REQ;
      r_pc     <= PC_RESET;
      r_drop   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_pc     <= w_pcNext;
      r_drop   <= w_dropNext;
      r_halted <= w_haltedNext;
    end
  end

  // Decode register: flush beats everything, then new data, then plain consumption.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idValid <= 1'b0;
      r_idInstr <= 32'd0;
      r_idPc    <= 32'd0;
      r_idPc4   <= 32'd0;
    end else if (w_flush) begin
      r_idValid <= 1'b0;
    end else if (w_loadResp) begin
      r_idValid <= 1'b1;
      r_idInstr <= imem_resp_data;
      r_idPc    <= r_pc;
      r_idPc4   <= w_pcPlus4;
    end else if (w_loadBuf) begin
      r_idValid <= 1'b1;
      r_idInstr <= r_bufInstr;
      r_idPc    <= r_bufPc;
      r_idPc4   <= r_bufPc4;
    end else if (w_handoff) begin
      r_idValid <= 1'b0;
    end
  end

  // Buffer contents are only meaningful while in HOLD; leaving HOLD is what empties it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bufInstr <= 32'd0;
      r_bufPc    <= 32'd0;
      r_bufPc4   <= 32'd0;
    end else if (w_fillBuf) begin
      r_bufInstr <= imem_resp_data;
      r_bufPc    <= r_pc;
      r_bufPc4   <= w_pcPlus4;
    end
  end

`ifdef PERF_COUNTER_EN
  logic [1:0]  w_dropInc;
  logic [31:0] r_perfFetched;
  logic [31:0] r_perfDropped;

  assign w_dropInc = {1'b0, w_discard}
                   + {1'b0, w_flush && r_idValid && !id_ready}
                   + {1'b0, w_flush && w_inHold};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perfFetched <= 32'd0;
      r_perfDropped <= 32'd0;
    end else begin
      r_perfFetched <= r_perfFetched + {31'd0, w_handoff};
      r_perfDropped <= r_perfDropped + {30'd0, w_dropInc};
    end
  end

  assign perf_fetched = r_perfFetched;
  assign perf_dropped = r_perfDropped;
`endif

endmodule
